// File: rtl/xcorr_delay_estimator.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : xcorr_delay_estimator                                        |
// | Description : Brute-force cross-correlation delay estimator. Captures a    |
// |               window from two mic channels, evaluates C(k) for every lag   |
// |               in -MAX_LAG..+MAX_LAG (one MAC per cycle) and reports the    |
// |               lag with the largest correlation.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module xcorr_delay_estimator #(
  parameter int WINDOW  = 256,
  parameter int MAX_LAG = 32,
  // Derived from WINDOW; leave at its default.
  parameter int ACC_W   = 32 + $clog2(WINDOW)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic                    sample_valid_in,
  input  logic signed [15:0]      mic_a_in,
  input  logic signed [15:0]      mic_b_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic signed [7:0]       lag_out,
  output logic signed [ACC_W-1:0] peak_out
);

  localparam int IDX_W = $clog2(WINDOW);

  localparam logic [1:0] c_S_IDLE    = 2'd0;
  localparam logic [1:0] c_S_CAPTURE = 2'd1;
  localparam logic [1:0] c_S_COMPUTE = 2'd2;
  localparam logic [1:0] c_S_DONE    = 2'd3;

  localparam logic signed [7:0]  c_LAG_MIN = 8'(-MAX_LAG);
  localparam logic signed [7:0]  c_LAG_MAX = 8'(MAX_LAG);
  localparam logic [IDX_W-1:0]   c_N_LAST  = IDX_W'(WINDOW - 1);
  localparam logic signed [11:0] c_WIN     = 12'(WINDOW);

  // Sample buffers (synchronous-read RAMs, contents not reset)
  logic signed [15:0] a_mem [WINDOW];
  logic signed [15:0] b_mem [WINDOW];
  logic signed [15:0] a_rd_q;
  logic signed [15:0] b_rd_q;

  // Control state
  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        cap_q, cap_d;
  logic [IDX_W-1:0]        n_q, n_d;
  logic signed [7:0]       lag_q, lag_d;
  logic                    issue_q, issue_d;

  // Stage 1: RAM read in flight
  logic                    v1_q, v1_d;
  logic                    m1_q, m1_d;
  logic                    f1_q, f1_d;
  logic                    l1_q, l1_d;
  logic signed [7:0]       lag1_q, lag1_d;

  // Stage 2: product register
  logic                    v2_q, v2_d;
  logic                    f2_q, f2_d;
  logic                    l2_q, l2_d;
  logic signed [7:0]       lag2_q, lag2_d;
  logic signed [31:0]      p2_q, p2_d;

  // Stage 3: accumulator and running best
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] best_q, best_d;
  logic signed [7:0]       best_lag_q, best_lag_d;
  logic signed [7:0]       lag_out_q, lag_out_d;
  logic signed [ACC_W-1:0] peak_out_q, peak_out_d;

  logic                    w_cap_we;
  logic signed [11:0]      w_b_idx;
  logic                    w_b_in_range;
  logic [IDX_W-1:0]        w_b_addr;
  logic signed [31:0]      w_prod;
  logic signed [ACC_W-1:0] w_sum;

  // Address generation for b[n+k]; out-of-window terms are masked, never read
  always_comb begin
    w_b_idx      = $signed({{(12-IDX_W){1'b0}}, n_q}) + $signed({{4{lag_q[7]}}, lag_q});
    w_b_in_range = !w_b_idx[11] && (w_b_idx < c_WIN);
    w_b_addr     = w_b_idx[IDX_W-1:0];
    w_prod       = 32'(a_rd_q) * 32'(b_rd_q);
    w_cap_we     = (state_q == c_S_CAPTURE) && sample_valid_in;
  end

  // Buffer write port: one sample pair per strobe while capturing
  always_ff @(posedge clk_in) begin
    if (w_cap_we) begin
      a_mem[cap_q] <= mic_a_in;
      b_mem[cap_q] <= mic_b_in;
    end
  end

  // Buffer read ports with one cycle of latency
  always_ff @(posedge clk_in) begin
    if (issue_q) begin
      a_rd_q <= a_mem[n_q];
    end
    if (issue_q && w_b_in_range) begin
      b_rd_q <= b_mem[w_b_addr];
    end
  end

  // Next-state logic: FSM, lag/index sweep, MAC pipeline and best-lag tracking
  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    n_d        = n_q;
    lag_d      = lag_q;
    issue_d    = issue_q;
    acc_d      = acc_q;
    best_d     = best_q;
    best_lag_d = best_lag_q;
    lag_out_d  = lag_out_q;
    peak_out_d = peak_out_q;

    w_sum = (f2_q ? '0 : acc_q) + {{(ACC_W-32){p2_q[31]}}, p2_q};

    v1_d   = issue_q;
    m1_d   = issue_q && w_b_in_range;
    f1_d   = (n_q == '0);
    l1_d   = (n_q == c_N_LAST);
    lag1_d = lag_q;

    v2_d   = v1_q;
    f2_d   = f1_q;
    l2_d   = l1_q;
    lag2_d = lag1_q;
    p2_d   = m1_q ? w_prod : '0;

    case (state_q)
      c_S_IDLE: begin
        if (start_in) begin
          state_d = c_S_CAPTURE;
          cap_d   = '0;
        end
      end
      c_S_CAPTURE: begin
        if (sample_valid_in) begin
          if (cap_q == c_N_LAST) begin
            state_d = c_S_COMPUTE;
            n_d     = '0;
            lag_d   = c_LAG_MIN;
            issue_d = 1'b1;
          end else begin
            cap_d = cap_q + IDX_W'(1);
          end
        end
      end
      c_S_COMPUTE: begin
        if (issue_q) begin
          if (n_q == c_N_LAST) begin
            n_d = '0;
            if (lag_q == c_LAG_MAX) begin
              issue_d = 1'b0;
            end else begin
              lag_d = lag_q + 8'sd1;
            end
          end else begin
            n_d = n_q + IDX_W'(1);
          end
        end
        if (v2_q) begin
          acc_d = w_sum;
          if (l2_q) begin
            // Strict compare: ties keep the earlier (more negative) lag
            if ((lag2_q == c_LAG_MIN) || (w_sum > best_q)) begin
              best_d     = w_sum;
              best_lag_d = lag2_q;
            end
            if (lag2_q == c_LAG_MAX) begin
              state_d    = c_S_DONE;
              lag_out_d  = best_lag_d;
              peak_out_d = best_d;
            end
          end
        end
      end
      c_S_DONE: begin
        state_d = c_S_IDLE;
      end
      default: begin
        state_d = c_S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= c_S_IDLE;
      cap_q      <= '0;
      n_q        <= '0;
      lag_q      <= '0;
      issue_q    <= 1'b0;
      v1_q       <= 1'b0;
      m1_q       <= 1'b0;
      f1_q       <= 1'b0;
      l1_q       <= 1'b0;
      lag1_q     <= '0;
      v2_q       <= 1'b0;
      f2_q       <= 1'b0;
      l2_q       <= 1'b0;
      lag2_q     <= '0;
      p2_q       <= '0;
      acc_q      <= '0;
      best_q     <= '0;
      best_lag_q <= '0;
      lag_out_q  <= '0;
      peak_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      n_q        <= n_d;
      lag_q      <= lag_d;
      issue_q    <= issue_d;
      v1_q       <= v1_d;
      m1_q       <= m1_d;
      f1_q       <= f1_d;
      l1_q       <= l1_d;
      lag1_q     <= lag1_d;
      v2_q       <= v2_d;
      f2_q       <= f2_d;
      l2_q       <= l2_d;
      lag2_q     <= lag2_d;
      p2_q       <= p2_d;
      acc_q      <= acc_d;
      best_q     <= best_d;
      best_lag_q <= best_lag_d;
      lag_out_q  <= lag_out_d;
      peak_out_q <= peak_out_d;
    end
  end

  assign busy_out = (state_q != c_S_IDLE);
  assign done_out = (state_q == c_S_DONE);
  assign lag_out  = lag_out_q;
  assign peak_out = peak_out_q;

endmodule
`default_nettype wire

// File: tb/tb_xcorr_delay_estimator.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_xcorr_delay_estimator                                     |
// | Description : Directed bench for xcorr_delay_estimator: table of impulse,  |
// |               zero and full-scale windows plus disturbance, reset and a    |
// |               small-window full-scale instance.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_xcorr_delay_estimator;

  localparam int WIN        = 256;
  localparam int MAXL       = 32;
  localparam int ACCW       = 32 + $clog2(WIN);
  localparam int WIN_S      = 16;
  localparam int MAXL_S     = 4;
  localparam int ACCW_S     = 32 + $clog2(WIN_S);
  localparam int LAT_BOUND  = (2*MAXL+1)*(WIN+4)+8;
  localparam int WAIT_LIMIT = 20000;

  typedef struct {
    string             name;
    int                a_pos;
    int                b_pos;
    int                amp;
    bit                fill_const;
    bit                disturb;
    logic signed [7:0] exp_lag;
    longint            exp_peak;
  } vec_t;

  logic clk = 1'b0;
  logic rst_in;
  logic start_in;
  logic start_s;
  logic sample_valid_in;
  logic signed [15:0] mic_a_in;
  logic signed [15:0] mic_b_in;

  logic                     busy_out;
  logic                     done_out;
  logic signed [7:0]        lag_out;
  logic signed [ACCW-1:0]   peak_out;
  logic                     busy_s;
  logic                     done_s;
  logic signed [7:0]        lag_s;
  logic signed [ACCW_S-1:0] peak_s;

  int n_checks = 0;
  int n_pass   = 0;
  int a_win [WIN];
  int b_win [WIN];
  vec_t vecs [3];

  always #5 clk = ~clk;

  xcorr_delay_estimator #(.WINDOW(WIN), .MAX_LAG(MAXL)) dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .sample_valid_in (sample_valid_in),
    .mic_a_in        (mic_a_in),
    .mic_b_in        (mic_b_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .lag_out         (lag_out),
    .peak_out        (peak_out)
  );

  xcorr_delay_estimator #(.WINDOW(WIN_S), .MAX_LAG(MAXL_S)) dut_s (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .start_in        (start_s),
    .sample_valid_in (sample_valid_in),
    .mic_a_in        (mic_a_in),
    .mic_b_in        (mic_b_in),
    .busy_out        (busy_s),
    .done_out        (done_s),
    .lag_out         (lag_s),
    .peak_out        (peak_s)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fill_window(input int a_pos, input int b_pos, input int amp, input bit fill_const);
    for (int i = 0; i < WIN; i++) begin
      a_win[i] = fill_const ? amp : 0;
      b_win[i] = fill_const ? amp : 0;
    end
    if (!fill_const) begin
      a_win[a_pos] = amp;
      b_win[b_pos] = amp;
    end
  endtask

  // Start (with a junk strobe in the start cycle that must be dropped), then feed the window
  task automatic start_and_feed(input string tag, input bit disturb);
    start_in = 1'b1; sample_valid_in = 1'b1;
    mic_a_in = 16'sd7777; mic_b_in = 16'sd7777;
    @(negedge clk);
    start_in = 1'b0; sample_valid_in = 1'b0;
    check({tag, ".busy_after_start"}, longint'(busy_out), 1);
    for (int i = 0; i < WIN; i++) begin
      if (disturb && i == 100) begin
        sample_valid_in = 1'b0; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
      end
      sample_valid_in = 1'b1;
      mic_a_in = 16'(a_win[i]);
      mic_b_in = 16'(b_win[i]);
      @(negedge clk);
    end
    sample_valid_in = 1'b0; mic_a_in = '0; mic_b_in = '0;
  endtask

  task automatic run_measure(input string tag, input bit disturb,
                             input logic signed [7:0] exp_lag, input longint exp_peak);
    int dones = 0;
    int lat   = 0;
    bit seen  = 1'b0;
    bit busy_again = 1'b0;
    start_and_feed(tag, disturb);
    for (int c = 0; c < WAIT_LIMIT && !seen; c++) begin
      start_in = (disturb && c == 100);
      if (disturb && c >= 100 && c < 105) begin
        sample_valid_in = 1'b1; mic_a_in = 16'sd12345; mic_b_in = 16'sd12345;
      end else begin
        sample_valid_in = 1'b0; mic_a_in = '0; mic_b_in = '0;
      end
      @(negedge clk);
      if (done_out) begin
        seen = 1'b1;
        dones++;
        lat = c + 1;
      end
    end
    start_in = 1'b0; sample_valid_in = 1'b0; mic_a_in = '0; mic_b_in = '0;
    check({tag, ".done_seen"}, longint'(seen), 1);
    if (seen) begin
      check({tag, ".latency_in_bound"}, longint'(lat <= LAT_BOUND), 1);
      check({tag, ".lag"}, longint'(lag_out), longint'(exp_lag));
      check({tag, ".peak"}, longint'(peak_out), exp_peak);
      if (disturb) start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      check({tag, ".busy_falls"}, longint'(busy_out), 0);
      for (int c = 0; c < 8; c++) begin
        if (done_out) dones++;
        if (busy_out) busy_again = 1'b1;
        @(negedge clk);
      end
      check({tag, ".single_done"}, longint'(dones), 1);
      check({tag, ".no_restart"}, longint'(busy_again), 0);
      check({tag, ".lag_held"}, longint'(lag_out), longint'(exp_lag));
    end
  endtask

  initial begin
    int  dones_r;
    bit  seen_s;

    vecs[0] = '{"s1_impulse_disturbed", 100, 105,   1000, 1'b0, 1'b1,  8'sd5,  64'sd1000000};
    vecs[1] = '{"s3_all_zero",            0,   0,      0, 1'b0, 1'b0, -8'sd32, 64'sd0};
    vecs[2] = '{"s4_full_scale",          0,   0, -32768, 1'b1, 1'b0,  8'sd0,  64'sd274877906944};

    rst_in = 1'b1; start_in = 1'b0; start_s = 1'b0;
    sample_valid_in = 1'b0; mic_a_in = '0; mic_b_in = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", longint'(busy_out), 0);
    check("reset.done", longint'(done_out), 0);
    check("reset.lag",  longint'(lag_out), 0);
    check("reset.peak", longint'(peak_out), 0);
    rst_in = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 3; v++) begin
      fill_window(vecs[v].a_pos, vecs[v].b_pos, vecs[v].amp, vecs[v].fill_const);
      run_measure(vecs[v].name, vecs[v].disturb, vecs[v].exp_lag, vecs[v].exp_peak);
    end

    // Full-scale bound at WINDOW=16: 16 * 2^30 at lag 0
    mic_a_in = -16'sd32768; mic_b_in = -16'sd32768;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int i = 0; i < WIN_S; i++) begin
      sample_valid_in = 1'b1;
      @(negedge clk);
    end
    sample_valid_in = 1'b0; mic_a_in = '0; mic_b_in = '0;
    seen_s = 1'b0;
    for (int c = 0; c < 2000 && !seen_s; c++) begin
      @(negedge clk);
      if (done_s) seen_s = 1'b1;
    end
    check("small.done_seen", longint'(seen_s), 1);
    check("small.lag",  longint'(lag_s), 0);
    check("small.peak", longint'(peak_s), 64'sd17179869184);
    check("small.main_idle_ignores_strobes", longint'(busy_out), 0);

    // Reset halfway through COMPUTE, then a fresh measurement on scenario-2 data
    fill_window(100, 105, 1000, 1'b0);
    start_and_feed("s6_pre_reset", 1'b0);
    dones_r = 0;
    for (int c = 0; c < 8300; c++) begin
      @(negedge clk);
      if (done_out) dones_r++;
    end
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    check("s6_reset.busy", longint'(busy_out), 0);
    check("s6_reset.done", longint'(done_out), 0);
    check("s6_reset.lag",  longint'(lag_out), 0);
    check("s6_reset.peak", longint'(peak_out), 0);
    for (int c = 0; c < 50; c++) begin
      if (done_out) dones_r++;
      @(negedge clk);
    end
    check("s6_reset.no_done", longint'(dones_r), 0);

    fill_window(60, 53, -2000, 1'b0);
    run_measure("s2_after_reset", 1'b0, -8'sd7, 64'sd4000000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
